// File: rtl/writeback_arb_pkg.sv
// -----------------------------------------------------------------------------
// writeback_arb_pkg
//   Shared definitions for the register-file writeback arbiter.
//   - wb_port_e  : fixed index of each writeback source on the arbiter.
//   - ptr_width(): width of a round-robin pointer able to address n ports.
// -----------------------------------------------------------------------------
package writeback_arb_pkg;

  typedef enum logic [2:0] {
    WB_PORT_ALU    = 3'd0,  // simple ALU pipe, cannot stall
    WB_PORT_LSU    = 3'd1,  // load/store unit
    WB_PORT_CALU   = 3'd2,  // complex ALU
    WB_PORT_BRANCH = 3'd3   // branch link
  } wb_port_e;

  // At least one bit, so a 1-port instance still has a legal vector.
  function automatic int ptr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// -----------------------------------------------------------------------------
// rr_priority_select
//   Combinational round-robin selector: finds the first set request bit when
//   scanning ptr_i, ptr_i+1, ... modulo N, and reports it as a one-hot grant
//   plus its encoded index. Equivalent to rotate / find-first / unrotate.
//   Ports:
//     req_i   [N-1:0]     request vector
//     ptr_i   [PTRW-1:0]  highest-priority index (must be < N)
//     grant_o [N-1:0]     one-hot grant, zero when no request
//     idx_o   [PTRW-1:0]  encoded grant index, zero when no request
//     valid_o             any request present
// -----------------------------------------------------------------------------
module rr_priority_select #(
  parameter int N    = 4,
  parameter int PTRW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [PTRW-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [PTRW-1:0] idx_o,
  output logic            valid_o
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      // Index wraps with a subtract rather than a modulo so non-power-of-two
      // N stays cheap.
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!valid_o && req_i[j]) begin
        valid_o    = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = PTRW'(j);
      end
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
//   Shares the single register-file write port between PORTCOUNT writeback
//   sources. One source is granted per enabled cycle (same-cycle ACK) and the
//   winner is registered into the write-port stage feeding the register file.
//   Optional build macro: WRITEBACK_ARB_PORT0_PRIORITY_EN
//     defined   - port 0 always wins when requesting; round-robin covers ports
//                 1..PORTCOUNT-1 only (pointer resets to 1, wraps to 1).
//     undefined - pure round-robin over all ports (pointer resets to 0).
//   Ports:
//     clk, clk_en, sync_rst        clock, global enable, sync active-high reset
//     WB_REQ/WB_ACK [PORTCOUNT]    per-source request / combinational grant
//     WB_Addr, WB_Data             flattened per-source address / data
//     RegWriteEn/AddrOut/DataOut   registered register-file write port
//     WritebackContentionOut       more than one source requesting this cycle
// -----------------------------------------------------------------------------
module writeback_arbiter
  import writeback_arb_pkg::*;
#(
  parameter int DATABITWIDTH    = 16,
  parameter int REGADDRBITWIDTH = 4,
  parameter int PORTCOUNT       = 4
) (
  input  logic                                 clk,
  input  logic                                 clk_en,
  input  logic                                 sync_rst,
  input  logic [PORTCOUNT-1:0]                 WB_REQ,
  output logic [PORTCOUNT-1:0]                 WB_ACK,
  input  logic [PORTCOUNT*REGADDRBITWIDTH-1:0] WB_Addr,
  input  logic [PORTCOUNT*DATABITWIDTH-1:0]    WB_Data,
  output logic                                 RegWriteEn,
  output logic [REGADDRBITWIDTH-1:0]           RegWriteAddrOut,
  output logic [DATABITWIDTH-1:0]              RegWriteDataOut,
  output logic                                 WritebackContentionOut
);

  localparam int PTRW = ptr_width(PORTCOUNT);

`ifdef WRITEBACK_ARB_PORT0_PRIORITY_EN
  localparam logic [PTRW-1:0] PTR_RST = PTRW'(1);
`else
  localparam logic [PTRW-1:0] PTR_RST = '0;
`endif

  logic [PTRW-1:0]            rr_ptr_q, rr_ptr_d;
  logic                       wr_en_q;
  logic [REGADDRBITWIDTH-1:0] wr_addr_q;
  logic [DATABITWIDTH-1:0]    wr_data_q;

  logic [PORTCOUNT-1:0] rr_req, rr_grant, grant_vec;
  logic [PTRW-1:0]      rr_idx, grant_idx;
  logic                 rr_vld, grant_vld, xfer;

  always_comb begin
    rr_req = WB_REQ;
`ifdef WRITEBACK_ARB_PORT0_PRIORITY_EN
    // Port 0 is handled by fixed priority; keep it out of the rotation.
    rr_req[int'(WB_PORT_ALU)] = 1'b0;
`endif
  end

  rr_priority_select #(
    .N    (PORTCOUNT),
    .PTRW (PTRW)
  ) u_rr_sel (
    .req_i   (rr_req),
    .ptr_i   (rr_ptr_q),
    .grant_o (rr_grant),
    .idx_o   (rr_idx),
    .valid_o (rr_vld)
  );

  always_comb begin
    grant_vec = rr_grant;
    grant_idx = rr_idx;
    grant_vld = rr_vld;
`ifdef WRITEBACK_ARB_PORT0_PRIORITY_EN
    if (WB_REQ[int'(WB_PORT_ALU)]) begin
      grant_vec = '0;
      grant_vec[int'(WB_PORT_ALU)] = 1'b1;
      grant_idx = PTRW'(WB_PORT_ALU);
      grant_vld = 1'b1;
    end
`endif
  end

  // Reset dominates the enable: no grant, hence no transfer, in a reset cycle.
  assign xfer   = clk_en && !sync_rst && grant_vld;
  assign WB_ACK = xfer ? grant_vec : '0;

  assign WritebackContentionOut = clk_en && ($countones(WB_REQ) > 1);

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
`ifdef WRITEBACK_ARB_PORT0_PRIORITY_EN
      if (grant_idx != PTRW'(WB_PORT_ALU))
`endif
        rr_ptr_d = (grant_idx == PTRW'(PORTCOUNT - 1)) ? PTR_RST
                                                         : grant_idx + PTRW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      rr_ptr_q  <= PTR_RST;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (clk_en) begin
      rr_ptr_q <= rr_ptr_d;
      wr_en_q  <= xfer;
      if (xfer) begin
        wr_addr_q <= WB_Addr[int'(grant_idx)*REGADDRBITWIDTH +: REGADDRBITWIDTH];
        wr_data_q <= WB_Data[int'(grant_idx)*DATABITWIDTH +: DATABITWIDTH];
      end
    end
  end

  assign RegWriteEn      = wr_en_q;
  assign RegWriteAddrOut = wr_addr_q;
  assign RegWriteDataOut = wr_data_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_writeback_arbiter
//   Self-checking bench for writeback_arbiter (4 ports, 4-bit address,
//   16-bit data). Directed scenarios for the default build, a port-0 priority
//   scenario when WRITEBACK_ARB_PORT0_PRIORITY_EN is defined, and a random
//   run checked against a behavioural model in both builds.
// -----------------------------------------------------------------------------
module tb_writeback_arbiter;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            clk_en, sync_rst;
  logic [N-1:0]    wb_req, wb_ack;
  logic [N*AW-1:0] wb_addr;
  logic [N*DW-1:0] wb_data;
  logic            reg_we, contention;
  logic [AW-1:0]   reg_addr;
  logic [DW-1:0]   reg_data;

  always #5 clk = ~clk;

  writeback_arbiter #(
    .DATABITWIDTH    (DW),
    .REGADDRBITWIDTH (AW),
    .PORTCOUNT       (N)
  ) dut (
    .clk                    (clk),
    .clk_en                 (clk_en),
    .sync_rst               (sync_rst),
    .WB_REQ                 (wb_req),
    .WB_ACK                 (wb_ack),
    .WB_Addr                (wb_addr),
    .WB_Data                (wb_data),
    .RegWriteEn             (reg_we),
    .RegWriteAddrOut        (reg_addr),
    .RegWriteDataOut        (reg_data),
    .WritebackContentionOut (contention)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [AW-1:0] src_addr [N];
  logic [DW-1:0] src_data [N];

`ifdef WRITEBACK_ARB_PORT0_PRIORITY_EN
  localparam int PTR_RST = 1;
`else
  localparam int PTR_RST = 0;
`endif

  // Model state: the write-port stage seen by the register file.
  int            m_ptr;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  // Winner index under the arbitration rule, -1 when nobody requests.
  function automatic int ref_grant(input logic [N-1:0] req, input int ptr);
`ifdef WRITEBACK_ARB_PORT0_PRIORITY_EN
    if (req[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr + k) % N;
`ifdef WRITEBACK_ARB_PORT0_PRIORITY_EN
      if (i == 0) continue;
`endif
      if (req[i]) return i;
    end
    return -1;
  endfunction

  function automatic int ref_next_ptr(input int g, input int ptr);
`ifdef WRITEBACK_ARB_PORT0_PRIORITY_EN
    if (g == 0) return ptr;
    return (g == N - 1) ? 1 : g + 1;
`else
    return (g + 1) % N;
`endif
  endfunction

  // Drive all inputs, then let combinational outputs settle.
  task automatic drive(input logic [N-1:0] req, input logic en, input logic rst);
    wb_req   = req;
    clk_en   = en;
    sync_rst = rst;
    for (int i = 0; i < N; i++) begin
      wb_addr[i*AW +: AW] = src_addr[i];
      wb_data[i*DW +: DW] = src_data[i];
    end
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    drive('0, 1'b1, 1'b1);
    tick();
  endtask

  task automatic load_sources;
    for (int i = 0; i < N; i++) begin
      src_addr[i] = AW'(i + 8);
      src_data[i] = DW'(16'hA000 + i * 16'h0111);
    end
  endtask

  task automatic test_reset;
    load_sources();
    // Reset must win even with clk_en low.
    drive(4'b1111, 1'b0, 1'b1);
    vectors++;
    if (wb_ack !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ack: got %b want 0000", wb_ack);
    end
    tick();
    vectors++;
    if ({reg_we, reg_addr, reg_data} !== {1'b0, 4'd0, 16'h0000}) begin
      miscompares++;
      $display("FAIL reset_regs: got we=%b a=%h d=%h want 0/0/0000", reg_we, reg_addr, reg_data);
    end
  endtask

`ifndef WRITEBACK_ARB_PORT0_PRIORITY_EN
  task automatic test_single;
    do_reset();
    load_sources();
    src_addr[1] = 4'd5;
    src_data[1] = 16'hBEEF;
    drive(4'b0010, 1'b1, 1'b0);
    vectors++;
    if ({wb_ack, contention} !== {4'b0010, 1'b0}) begin
      miscompares++;
      $display("FAIL single_ack: got ack=%b cont=%b want 0010/0", wb_ack, contention);
    end
    tick();
    vectors++;
    if ({reg_we, reg_addr, reg_data} !== {1'b1, 4'd5, 16'hBEEF}) begin
      miscompares++;
      $display("FAIL single_regs: got we=%b a=%h d=%h want 1/5/beef", reg_we, reg_addr, reg_data);
    end
    // Pointer now 2: with all requesting, port 2 wins.
    drive(4'b1111, 1'b1, 1'b0);
    vectors++;
    if (wb_ack !== 4'b0100) begin
      miscompares++;
      $display("FAIL single_ptr: got %b want 0100", wb_ack);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      src_addr[3] = AW'(c + 1);
      src_data[3] = DW'(16'h3300 + c);
      drive(4'b1000, 1'b1, 1'b0);
      vectors++;
      if (wb_ack !== 4'b1000) begin
        miscompares++;
        $display("FAIL b2b_ack%0d: got %b want 1000", c, wb_ack);
      end
      tick();
      vectors++;
      if ({reg_we, reg_addr, reg_data} !== {1'b1, 4'(c + 1), 16'(16'h3300 + c)}) begin
        miscompares++;
        $display("FAIL b2b_regs%0d: got we=%b a=%h d=%h", c, reg_we, reg_addr, reg_data);
      end
    end
  endtask

  task automatic test_all_req;
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    load_sources();
    for (int c = 0; c < 5; c++) begin
      drive(4'b1111, 1'b1, 1'b0);
      vectors++;
      if ({wb_ack, contention} !== {4'(1 << order[c]), 1'b1}) begin
        miscompares++;
        $display("FAIL allreq_ack%0d: got ack=%b cont=%b want port %0d, cont 1", c, wb_ack, contention, order[c]);
      end
      tick();
      vectors++;
      if ({reg_we, reg_addr, reg_data} !== {1'b1, src_addr[order[c]], src_data[order[c]]}) begin
        miscompares++;
        $display("FAIL allreq_regs%0d: got we=%b a=%h d=%h", c, reg_we, reg_addr, reg_data);
      end
    end
  endtask

  task automatic test_wrap;
    do_reset();
    load_sources();
    drive(4'b0100, 1'b1, 1'b0);  // grant 2, pointer -> 3
    tick();
    drive(4'b0101, 1'b1, 1'b0);
    vectors++;
    if (wb_ack !== 4'b0001) begin
      miscompares++;
      $display("FAIL wrap_ack0: got %b want 0001", wb_ack);
    end
    tick();
    drive(4'b0101, 1'b1, 1'b0);
    vectors++;
    if (wb_ack !== 4'b0100) begin
      miscompares++;
      $display("FAIL wrap_ack1: got %b want 0100", wb_ack);
    end
    tick();
  endtask

  task automatic test_clk_en;
    do_reset();
    load_sources();
    drive(4'b0001, 1'b1, 1'b0);  // grant 0, pointer -> 1
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(4'b0011, 1'b0, 1'b0);
      vectors++;
      if ({wb_ack, contention} !== {4'b0000, 1'b0}) begin
        miscompares++;
        $display("FAIL clken_ack%0d: got ack=%b cont=%b want 0000/0", c, wb_ack, contention);
      end
      tick();
      vectors++;
      if ({reg_we, reg_addr, reg_data} !== {1'b1, src_addr[0], src_data[0]}) begin
        miscompares++;
        $display("FAIL clken_hold%0d: got we=%b a=%h d=%h", c, reg_we, reg_addr, reg_data);
      end
    end
    drive(4'b0011, 1'b1, 1'b0);
    vectors++;
    if ({wb_ack, contention} !== {4'b0010, 1'b1}) begin
      miscompares++;
      $display("FAIL clken_resume: got ack=%b cont=%b want 0010/1", wb_ack, contention);
    end
    tick();
    vectors++;
    if ({reg_we, reg_addr, reg_data} !== {1'b1, src_addr[1], src_data[1]}) begin
      miscompares++;
      $display("FAIL clken_resume_regs: got we=%b a=%h d=%h", reg_we, reg_addr, reg_data);
    end
  endtask

  task automatic test_sync_rst;
    do_reset();
    load_sources();
    drive(4'b0010, 1'b1, 1'b0);  // grant 1, pointer -> 2
    tick();
    drive(4'b1000, 1'b1, 1'b1);
    vectors++;
    if (wb_ack !== 4'b0000) begin
      miscompares++;
      $display("FAIL rst_ack: got %b want 0000", wb_ack);
    end
    tick();
    vectors++;
    if ({reg_we, reg_addr, reg_data} !== {1'b0, 4'd0, 16'h0000}) begin
      miscompares++;
      $display("FAIL rst_regs: got we=%b a=%h d=%h want 0/0/0000", reg_we, reg_addr, reg_data);
    end
    // Pointer back at 0: port 1 beats port 3 (a surviving pointer of 2 would pick 3).
    drive(4'b1010, 1'b1, 1'b0);
    vectors++;
    if (wb_ack !== 4'b0010) begin
      miscompares++;
      $display("FAIL rst_ptr: got %b want 0010", wb_ack);
    end
    tick();
    drive(4'b1000, 1'b1, 1'b0);
    vectors++;
    if (wb_ack !== 4'b1000) begin
      miscompares++;
      $display("FAIL rst_port3: got %b want 1000", wb_ack);
    end
    tick();
    vectors++;
    if ({reg_we, reg_addr, reg_data} !== {1'b1, src_addr[3], src_data[3]}) begin
      miscompares++;
      $display("FAIL rst_port3_regs: got we=%b a=%h d=%h", reg_we, reg_addr, reg_data);
    end
  endtask
`else
  task automatic test_port0_priority;
    do_reset();
    load_sources();
    for (int c = 0; c < 3; c++) begin
      drive(4'b0011, 1'b1, 1'b0);
      vectors++;
      if ({wb_ack, contention} !== {4'b0001, 1'b1}) begin
        miscompares++;
        $display("FAIL p0_ack%0d: got ack=%b cont=%b want 0001/1", c, wb_ack, contention);
      end
      tick();
      vectors++;
      if ({reg_we, reg_addr, reg_data} !== {1'b1, src_addr[0], src_data[0]}) begin
        miscompares++;
        $display("FAIL p0_regs%0d: got we=%b a=%h d=%h", c, reg_we, reg_addr, reg_data);
      end
    end
    drive(4'b0010, 1'b1, 1'b0);
    vectors++;
    if (wb_ack !== 4'b0010) begin
      miscompares++;
      $display("FAIL p0_release: got %b want 0010", wb_ack);
    end
    tick();
    vectors++;
    if ({reg_we, reg_addr, reg_data} !== {1'b1, src_addr[1], src_data[1]}) begin
      miscompares++;
      $display("FAIL p0_release_regs: got we=%b a=%h d=%h", reg_we, reg_addr, reg_data);
    end
  endtask
`endif

  task automatic test_random;
    logic [N-1:0] req, exp_ack;
    logic         en, rst, exp_cont;
    int           g;
    do_reset();
    m_ptr  = PTR_RST;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
    req     = '0;
    exp_ack = '0;
    for (int c = 0; c < 400; c++) begin
      // Unacknowledged requests usually hold with stable fields; otherwise
      // the source withdraws or issues a fresh request.
      for (int i = 0; i < N; i++) begin
        if (!(req[i] && !exp_ack[i] && $urandom_range(7) != 0)) begin
          req[i]      = ($urandom_range(2) != 0);
          src_addr[i] = AW'($urandom);
          src_data[i] = DW'($urandom);
        end
      end
      en  = ($urandom_range(7) != 0);
      rst = ($urandom_range(49) == 0);
      drive(req, en, rst);

      g        = (en && !rst) ? ref_grant(req, m_ptr) : -1;
      exp_ack  = (g >= 0) ? N'(1 << g) : '0;
      exp_cont = en && ($countones(req) > 1);
      vectors++;
      if ({wb_ack, contention} !== {exp_ack, exp_cont}) begin
        miscompares++;
        $display("FAIL rand_ack c=%0d req=%b: got ack=%b cont=%b want ack=%b cont=%b",
                 c, req, wb_ack, contention, exp_ack, exp_cont);
      end
      tick();

      if (rst) begin
        m_ptr  = PTR_RST;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
      end else if (en) begin
        m_we = (g >= 0);
        if (g >= 0) begin
          m_addr = src_addr[g];
          m_data = src_data[g];
          m_ptr  = ref_next_ptr(g, m_ptr);
        end
      end
      vectors++;
      if ({reg_we, reg_addr, reg_data} !== {m_we, m_addr, m_data}) begin
        miscompares++;
        $display("FAIL rand_regs c=%0d: got we=%b a=%h d=%h want we=%b a=%h d=%h",
                 c, reg_we, reg_addr, reg_data, m_we, m_addr, m_data);
      end
    end
  endtask

  initial begin
    test_reset();
`ifndef WRITEBACK_ARB_PORT0_PRIORITY_EN
    test_single();
    test_back_to_back();
    test_all_req();
    test_wrap();
    test_clk_en();
    test_sync_rst();
`else
    test_port0_priority();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
